if_id_stage: RTL and testbench

- Fetch-side consumer of the hazard unit's control outputs: PC register, next-PC selection, IF/ID pipeline register.
- Applies PC-write stall, IF/ID-write stall and IF/ID flush requests, plus branch/jump redirects resolved downstream.
- Tracks fetch state and keeps saturating stall/flush counters for performance debug.
- Sits between the instruction memory and the decode stage.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sat_counter.sv | 25 ++
 rtl/if_id_stage.sv | 108 ++++++++++
 tb/tb_if_id_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: fetch state encodings, reset/bubble
// defaults and a helper that word-aligns redirect targets.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_STALL = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam int          CNT_W_DEFAULT    = 16;

    // Instructions are word aligned, so the low two address bits of a
    // redirect target carry no information and are forced to zero.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug: counts cycles in which inc
// is high, sticks at all-ones instead of wrapping, clr wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Synchronous clear, otherwise increment until the all-ones ceiling.
    always_ff @(posedge Clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register. Consumes the hazard unit's
// stall/flush controls and downstream branch/jump redirects, drives the
// instruction memory address and presents the fetched word to decode.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
    parameter int          CNT_W    = CNT_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PCWrite,
    input  logic             FDWrite,
    input  logic             rstFD,
    input  logic             redirect,
    input  logic [31:0]      redirectPC,
    output logic [31:0]      imemAddr,
    input  logic [31:0]      imemData,
    output logic [31:0]      instructionD,
    output logic [31:0]      pcPlus4D,
    output logic             validD,
    output logic [1:0]       fetchState,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_pcPlus4;
    logic         r_valid;
    fetch_state_e r_state;
    fetch_state_e w_nextState;
    logic [31:0]  w_pcPlus4;
    logic         w_flushFD;
    logic         w_stallInc;

    assign w_pcPlus4  = r_pc + 32'd4;
    assign w_flushFD  = rstFD | redirect;
    assign w_stallInc = ~redirect & ~PCWrite;

    // PC register: a redirect overrides a hazard stall, otherwise advance
    // (wrapping naturally at 2^32) when the hazard unit allows it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc <= PC_RESET;
        end else if (redirect) begin
            r_pc <= alignPc(redirectPC);
        end else if (PCWrite) begin
            r_pc <= w_pcPlus4;
        end
    end

    // IF/ID register: a redirect always squashes the wrong-path word
    // fetched this cycle, so it shares the bubble path with rstFD.
    always_ff @(posedge Clk) begin
        if (Rst || w_flushFD) begin
            r_instr   <= NOP_WORD;
            r_pcPlus4 <= 32'd0;
            r_valid   <= 1'b0;
        end else if (FDWrite) begin
            r_instr   <= imemData;
            r_pcPlus4 <= w_pcPlus4;
            r_valid   <= 1'b1;
        end
    end

    // Fetch state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= FETCH_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fetch state reflects what this cycle's controls did to the pipe:
    // any flush dominates, then any stall, otherwise free running.
    always_comb begin
        w_nextState = FETCH_RUN;
        if (w_flushFD) begin
            w_nextState = FETCH_FLUSH;
        end else if (!PCWrite || !FDWrite) begin
            w_nextState = FETCH_STALL;
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCounter (
        .Clk   (Clk),
        .clr   (Rst),
        .inc   (w_stallInc),
        .count (stallCount)
    );

    sat_counter #(.W(CNT_W)) u_flushCounter (
        .Clk   (Clk),
        .clr   (Rst),
        .inc   (w_flushFD),
        .count (flushCount)
    );

    assign imemAddr     = r_pc;
    assign instructionD = r_instr;
    assign pcPlus4D     = r_pcPlus4;
    assign validD       = r_valid;
    assign fetchState   = r_state;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: each driven cycle pushes the expected
// post-edge outputs, which are popped and compared one time unit after
// the rising edge. A few hand-computed constants back up the model.
module tb_if_id_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        PCWrite;
    logic        FDWrite;
    logic        rstFD;
    logic        redirect;
    logic [31:0] redirectPC;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] instructionD;
    logic [31:0] pcPlus4D;
    logic        validD;
    logic [1:0]  fetchState;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sbq[$];

    // Reference state of the fetch stage as the bench understands it.
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPcp4;
    logic        mValid;
    logic [1:0]  mSt;
    logic [15:0] mSc;
    logic [15:0] mFc;
    bit          mKnown = 1'b0;

    if_id_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .PCWrite      (PCWrite),
        .FDWrite      (FDWrite),
        .rstFD        (rstFD),
        .redirect     (redirect),
        .redirectPC   (redirectPC),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .instructionD (instructionD),
        .pcPlus4D     (pcPlus4D),
        .validD       (validD),
        .fetchState   (fetchState),
        .stallCount   (stallCount),
        .flushCount   (flushCount)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic drainScoreboard();
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("sbEmpty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput({e.tag, ".pc"},    imemAddr,     e.pc);
            checkOutput({e.tag, ".instr"}, instructionD, e.instr);
            checkOutput({e.tag, ".pcp4"},  pcPlus4D,     e.pcp4);
            checkOutput({e.tag, ".valid"}, {31'd0, validD},     {31'd0, e.valid});
            checkOutput({e.tag, ".state"}, {30'd0, fetchState}, {30'd0, e.st});
            checkOutput({e.tag, ".stall"}, {16'd0, stallCount}, {16'd0, e.sc});
            checkOutput({e.tag, ".flush"}, {16'd0, flushCount}, {16'd0, e.fc});
        end
    endtask

    // Drive one cycle of controls, advance the reference, and (optionally)
    // verify the result after the edge.
    task automatic applyStimulus(input bit rst, input bit pcw, input bit fdw,
                                 input bit rfd, input bit red,
                                 input logic [31:0] rpc, input logic [31:0] data,
                                 input string tag, input bit doCheck);
        exp_t        e;
        logic [31:0] oldPc;
        bit          squash;
        @(negedge Clk);
        Rst = rst; PCWrite = pcw; FDWrite = fdw; rstFD = rfd;
        redirect = red; redirectPC = rpc; imemData = data;
        #1;
        if (doCheck && mKnown) checkOutput({tag, ".addr"}, imemAddr, mPc);
        oldPc  = mPc;
        squash = rfd || red;
        if (rst) begin
            mPc = 32'h0; mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
            mSt = 2'd0; mSc = 16'd0; mFc = 16'd0; mKnown = 1'b1;
        end else begin
            mPc = red ? (rpc & 32'hFFFF_FFFC) : (pcw ? oldPc + 32'd4 : oldPc);
            if (squash) begin
                mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
            end else if (fdw) begin
                mInstr = data; mPcp4 = oldPc + 32'd4; mValid = 1'b1;
            end
            mSt = squash ? 2'd2 : ((!pcw || !fdw) ? 2'd1 : 2'd0);
            if (!red && !pcw && mSc != 16'hFFFF) mSc = mSc + 16'd1;
            if (squash && mFc != 16'hFFFF) mFc = mFc + 16'd1;
        end
        if (doCheck) begin
            e.tag = tag; e.pc = mPc; e.instr = mInstr; e.pcp4 = mPcp4;
            e.valid = mValid; e.st = mSt; e.sc = mSc; e.fc = mFc;
            sbq.push_back(e);
        end
        @(posedge Clk);
        #1;
        if (doCheck) drainScoreboard();
    endtask

    initial begin
        Rst = 1'b1; PCWrite = 1'b1; FDWrite = 1'b1; rstFD = 1'b0;
        redirect = 1'b0; redirectPC = 32'h0; imemData = 32'h2008_0005;

        // Reset then free run.
        applyStimulus(1, 1, 1, 0, 0, 32'h0, 32'h2008_0005, "rst0", 1);
        applyStimulus(1, 1, 1, 0, 0, 32'h0, 32'h2008_0005, "rst1", 1);
        checkOutput("rstValid", {31'd0, validD}, 32'd0);
        checkOutput("rstPc", imemAddr, 32'h0);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h2008_0005, "run0", 1);
        checkOutput("firstInstr", instructionD, 32'h2008_0005);
        checkOutput("firstPcp4", pcPlus4D, 32'h4);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h2008_0005, "run1", 1);
        checkOutput("pcAt8", imemAddr, 32'h8);

        // Load-use stall for two cycles, then resume.
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, "stall0", 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, "stall1", 1);
        checkOutput("stallHoldPc", imemAddr, 32'h8);
        checkOutput("stallCnt2", {16'd0, stallCount}, 32'd2);
        checkOutput("stallState", {30'd0, fetchState}, 32'd1);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0000_1111, "resume", 1);
        checkOutput("resumePc", imemAddr, 32'd12);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0000_2222, "run2", 1);

        // rstFD alone at PC=16.
        applyStimulus(0, 1, 1, 1, 0, 32'h0, 32'h0000_3333, "rstFD", 1);
        checkOutput("rstFDPc", imemAddr, 32'd20);
        checkOutput("rstFDCnt", {16'd0, flushCount}, 32'd1);
        checkOutput("rstFDValid", {31'd0, validD}, 32'd0);

        // Redirect during a stall: target alignment and counter effects.
        applyStimulus(0, 0, 1, 0, 1, 32'h0000_0043, 32'h0000_4444, "redir", 1);
        checkOutput("redirPc", imemAddr, 32'h40);
        checkOutput("redirInstr", instructionD, 32'h0);
        checkOutput("redirState", {30'd0, fetchState}, 32'd2);
        checkOutput("redirFlush", {16'd0, flushCount}, 32'd2);
        checkOutput("redirStall", {16'd0, stallCount}, 32'd2);

        // Random mix of controls.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                          $urandom, $urandom, "rand", 1);
        end

        // PC wrap at the top of the address space.
        applyStimulus(0, 1, 1, 0, 1, 32'hFFFF_FFFA, 32'h0, "preset", 1);
        checkOutput("wrapA", imemAddr, 32'hFFFF_FFF8);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0000_5555, "wrap0", 1);
        checkOutput("wrapB", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0000_6666, "wrap1", 1);
        checkOutput("wrapC", imemAddr, 32'h0);
        checkOutput("wrapPcp4", pcPlus4D, 32'h0);

        // Long stall to saturate the stall counter.
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0000_7777, "sat", 0);
        end
        applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0000_7777, "satEnd", 1);
        checkOutput("stallSat", {16'd0, stallCount}, 32'h0000_FFFF);

        // Reset mid-stall with a redirect that must be dropped.
        applyStimulus(1, 0, 0, 0, 1, 32'h0000_0100, 32'h0000_8888, "midRst", 1);
        checkOutput("midRstPc", imemAddr, 32'h0);
        checkOutput("midRstStall", {16'd0, stallCount}, 32'd0);
        checkOutput("midRstFlush", {16'd0, flushCount}, 32'd0);
        checkOutput("midRstState", {30'd0, fetchState}, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 32'h0, 32'h0000_9999, "post", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
